// File: rtl/vec_lane_sequencer.sv
// Vector load/store/add/sub sequencer moving one element per cycle over the scalar memory port.
// Define VEC_SAT_EN to enable signed per-lane saturation for VADD/VSUB (default: wrap mod 2^W).
module vec_lane_sequencer #(
    parameter int LANES = 4,
    parameter int W     = 8,
    parameter int AW    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [AW-1:0]        base_addr,
    input  logic [LANES*W-1:0]   src1,
    input  logic [LANES*W-1:0]   src2,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [W-1:0]         mem_wdata,
    input  logic [W-1:0]         mem_rdata,
    output logic                 vrf_we,
    output logic [LANES*W-1:0]   vrf_wdata,
    output logic                 sat,
    output logic [2:0]           dbg_state
);
    localparam int CW = $clog2(LANES + 1);
`ifdef VEC_SAT_EN
    localparam int EW = W + 1;
`else
    localparam int EW = W;
`endif

    // Handshake: start is sampled only in IDLE; busy is high in every other state,
    // done and vrf_we pulse for exactly one cycle at completion.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sub_q;
    logic [AW-1:0]        base_q, addr_d;
    logic [LANES*W-1:0]   x1_q, x2_q, res_q, load_d, alu_d;
    logic [W-1:0]         st_data_d;
    logic                 alu_sat_d;
    logic [EW-1:0]        lane_a, lane_b, lane_s;
    logic                 busy_q, done_q, rd_q, wr_q, we_q, sat_q;
    logic [AW-1:0]        addr_q;
    logic [W-1:0]         wdata_q;
    logic [LANES*W-1:0]   vrf_q;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        addr_d    = base_q + AW'(cnt_d);
        st_data_d = x1_q[int'(cnt_d)*W +: W];
        load_d    = res_q;
        // Data for the read issued at k-1 arrives while the counter reads k.
        if (cnt_q != '0) begin
            load_d[(int'(cnt_q)-1)*W +: W] = mem_rdata;
        end
    end

    always_comb begin
        alu_d     = '0;
        alu_sat_d = 1'b0;
        lane_a    = '0;
        lane_b    = '0;
        lane_s    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = EW'($signed(x1_q[i*W +: W]));
            lane_b = EW'($signed(x2_q[i*W +: W]));
            lane_s = sub_q ? (lane_a - lane_b) : (lane_a + lane_b);
`ifdef VEC_SAT_EN
            if (lane_s[W] != lane_s[W-1]) begin
                alu_d[i*W +: W] = lane_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                alu_sat_d       = 1'b1;
            end else begin
                alu_d[i*W +: W] = lane_s[W-1:0];
            end
`else
            alu_d[i*W +: W] = lane_s;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            base_q  <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            we_q    <= 1'b0;
            sat_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            vrf_q   <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sub_q  <= op[0];
                        base_q <= base_addr;
                        x1_q   <= src1;
                        x2_q   <= src2;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        case (op)
                            2'b00: begin
                                state_q <= S_LOAD;
                                rd_q    <= 1'b1;
                                addr_q  <= base_addr;
                            end
                            2'b01: begin
                                state_q <= S_STORE;
                                wr_q    <= 1'b1;
                                addr_q  <= base_addr;
                                wdata_q <= src1[W-1:0];
                            end
                            default: state_q <= S_EXEC;
                        endcase
                    end
                end
                S_LOAD: begin
                    res_q <= load_d;
                    if (cnt_q == CW'(LANES)) begin
                        state_q <= S_WB;
                        vrf_q   <= load_d;
                        we_q    <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                        if (int'(cnt_d) < LANES) begin
                            rd_q   <= 1'b1;
                            addr_q <= addr_d;
                        end
                    end
                end
                S_STORE: begin
                    if (cnt_q == CW'(LANES - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                        wr_q    <= 1'b1;
                        addr_q  <= addr_d;
                        wdata_q <= st_data_d;
                    end
                end
                S_EXEC: begin
                    state_q <= S_WB;
                    res_q   <= alu_d;
                    vrf_q   <= alu_d;
                    sat_q   <= alu_sat_d;
                    we_q    <= 1'b1;
                    done_q  <= 1'b1;
                end
                S_WB, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A write pending when reset arrives must not commit at that same edge.
    assign mem_wr    = wr_q & ~reset;
    assign mem_rd    = rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vrf_we    = we_q;
    assign vrf_wdata = vrf_q;
    assign sat       = sat_q;
    assign dbg_state = state_q;
endmodule
